// File: rtl/reg_map_pkg.sv
// Register map, timing field layout and reset timings for the LCD timing controller.
// Shared by the controller top and its per-axis raster generator.
package reg_map_pkg;

  localparam logic [31:0] BASE_LCD_CTRL = 32'hf800_2000;

  localparam logic [4:0] R_LCD_CTRL      = 5'h00;
  localparam logic [4:0] R_LCD_HTIM0     = 5'h04;
  localparam logic [4:0] R_LCD_HTIM1     = 5'h08;
  localparam logic [4:0] R_LCD_VTIM0     = 5'h0C;
  localparam logic [4:0] R_LCD_VTIM1     = 5'h10;
  localparam logic [4:0] R_LCD_POS       = 5'h14;
  localparam logic [4:0] R_LCD_FRAME_CNT = 5'h18;

  typedef struct packed {
    logic [9:0] sync;
    logic [9:0] bp;
    logic [9:0] act;
    logic [9:0] fp;
  } lcd_axis_t;

  localparam lcd_axis_t LCD_H_DEFAULT = '{sync: 10'd30, bp: 10'd29, act: 10'd320, fp: 10'd29};
  localparam lcd_axis_t LCD_V_DEFAULT = '{sync: 10'd8,  bp: 10'd7,  act: 10'd480, fp: 10'd7};

  // Deliberately 12-bit: oversized programming wraps rather than widening the counters.
  function automatic logic [11:0] axis_total(input lcd_axis_t a);
    return 12'(a.sync) + 12'(a.bp) + 12'(a.act) + 12'(a.fp);
  endfunction

endpackage

// File: rtl/lcd_axis_gen.sv
// One raster axis: position counter with wrap, plus sync and active-area decode.
// Wrap and decode are combinational from the registered position; pos updates one clk after step.
module lcd_axis_gen
  import reg_map_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  lcd_axis_t   cfg_i,
  input  logic        step_i,
  input  logic        clr_i,
  output logic [11:0] pos_o,
  output logic        wrap_o,
  output logic        sync_n_o,
  output logic        active_o
);

  logic [11:0] pos_q, pos_d;
  logic [11:0] total, last, act_start, act_end;

  // A zero total behaves as a one-position axis so the counter parks at 0.
  always_comb begin
    total     = axis_total(cfg_i);
    last      = (total == 12'd0) ? 12'd0 : total - 12'd1;
    act_start = 12'(cfg_i.sync) + 12'(cfg_i.bp);
    act_end   = act_start + 12'(cfg_i.act);
  end

  assign wrap_o   = step_i && (pos_q == last);
  assign sync_n_o = (pos_q >= 12'(cfg_i.sync));
  assign active_o = (cfg_i.act != 10'd0) && (pos_q >= act_start) && (pos_q < act_end);
  assign pos_o    = pos_q;

  always_comb begin
    pos_d = pos_q;
    if (clr_i) begin
      pos_d = 12'd0;
    end else if (wrap_o) begin
      pos_d = 12'd0;
    end else if (step_i) begin
      pos_d = pos_q + 12'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos_q <= 12'd0;
    end else begin
      pos_q <= pos_d;
    end
  end

endmodule

// File: rtl/lcd_timing_ctrl.sv
// Bus-programmable LCD raster timing: pixel strobe, h/v counters, registered sync/data_en/dotclk.
// LCD outputs lag the counters by one clk; timing writes are shadowed until the frame wrap.
module lcd_timing_ctrl
  import reg_map_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter logic [31:0] BASE    = BASE_LCD_CTRL
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic        bus_wen,
  input  logic        bus_ren,
  output logic [31:0] bus_rdata,
  output logic        pix_en,
  output logic [11:0] hpos,
  output logic [11:0] vpos,
  output logic        frame_start,
  output logic        lcd_dotclk,
  output logic        lcd_hsync,
  output logic        lcd_vsync,
  output logic        lcd_data_en
);

  localparam int unsigned DW = $clog2(CLK_DIV);

  logic [DW-1:0] div_q, div_d;
  logic          en_q, en_d, pending_q, pending_d;
  lcd_axis_t     h_stage_q, h_stage_d, v_stage_q, v_stage_d;
  lcd_axis_t     h_cur_q, h_cur_d, v_cur_q, v_cur_d;
  logic [31:0]   fcnt_q, fcnt_d;
  logic          dotclk_q, dotclk_d, hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;

  logic        hit, run, clr, frame_wrap, load, stage_wr;
  logic [4:0]  off;
  logic        h_wrap, v_wrap, h_sync_n, v_sync_n, h_act, v_act;
  logic        unused_bits;

  assign hit = (bus_addr[31:5] == BASE[31:5]);
  assign off = bus_addr[4:0];
  assign unused_bits = ^{bus_ren, bus_wdata[31:26], bus_wdata[15:10]};

  // Stop on the edge that clears EN so the counters already read 0 in the following cycle.
  assign run = en_q && en_d;
  assign clr = !run;

  assign pix_en      = rst_n && en_q && (div_q == '0);
  assign frame_wrap  = h_wrap && v_wrap;
  assign frame_start = frame_wrap;
  assign load        = frame_wrap || !en_q;

  lcd_axis_gen u_hgen (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_i    (h_cur_q),
    .step_i   (pix_en),
    .clr_i    (clr),
    .pos_o    (hpos),
    .wrap_o   (h_wrap),
    .sync_n_o (h_sync_n),
    .active_o (h_act)
  );

  lcd_axis_gen u_vgen (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_i    (v_cur_q),
    .step_i   (h_wrap),
    .clr_i    (clr),
    .pos_o    (vpos),
    .wrap_o   (v_wrap),
    .sync_n_o (v_sync_n),
    .active_o (v_act)
  );

  always_comb begin
    en_d      = en_q;
    pending_d = pending_q;
    h_stage_d = h_stage_q;
    v_stage_d = v_stage_q;
    h_cur_d   = h_cur_q;
    v_cur_d   = v_cur_q;
    fcnt_d    = fcnt_q;
    stage_wr  = 1'b0;

    // Load takes the pre-write staging value; a same-cycle write keeps PENDING set.
    if (load) begin
      h_cur_d   = h_stage_q;
      v_cur_d   = v_stage_q;
      pending_d = 1'b0;
    end
    if (frame_wrap) begin
      fcnt_d = fcnt_q + 32'd1;
    end

    if (bus_wen && hit) begin
      case (off)
        R_LCD_CTRL: en_d = bus_wdata[0];
        R_LCD_HTIM0: begin
          h_stage_d.sync = bus_wdata[9:0];
          h_stage_d.bp   = bus_wdata[25:16];
          stage_wr       = 1'b1;
        end
        R_LCD_HTIM1: begin
          h_stage_d.act = bus_wdata[9:0];
          h_stage_d.fp  = bus_wdata[25:16];
          stage_wr      = 1'b1;
        end
        R_LCD_VTIM0: begin
          v_stage_d.sync = bus_wdata[9:0];
          v_stage_d.bp   = bus_wdata[25:16];
          stage_wr       = 1'b1;
        end
        R_LCD_VTIM1: begin
          v_stage_d.act = bus_wdata[9:0];
          v_stage_d.fp  = bus_wdata[25:16];
          stage_wr      = 1'b1;
        end
        R_LCD_FRAME_CNT: fcnt_d = 32'd0;
        default: ;
      endcase
    end
    if (stage_wr) begin
      pending_d = 1'b1;
    end

    div_d    = run ? div_q + DW'(1) : '0;
    dotclk_d = div_q[DW-1];
    hsync_d  = !en_q || h_sync_n;
    vsync_d  = !en_q || v_sync_n;
    de_d     = en_q && h_act && v_act;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q     <= '0;
      en_q      <= 1'b1;
      pending_q <= 1'b0;
      h_stage_q <= LCD_H_DEFAULT;
      v_stage_q <= LCD_V_DEFAULT;
      h_cur_q   <= LCD_H_DEFAULT;
      v_cur_q   <= LCD_V_DEFAULT;
      fcnt_q    <= 32'd0;
      dotclk_q  <= 1'b0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      de_q      <= 1'b0;
    end else begin
      div_q     <= div_d;
      en_q      <= en_d;
      pending_q <= pending_d;
      h_stage_q <= h_stage_d;
      v_stage_q <= v_stage_d;
      h_cur_q   <= h_cur_d;
      v_cur_q   <= v_cur_d;
      fcnt_q    <= fcnt_d;
      dotclk_q  <= dotclk_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      de_q      <= de_d;
    end
  end

  assign lcd_dotclk  = dotclk_q;
  assign lcd_hsync   = hsync_q;
  assign lcd_vsync   = vsync_q;
  assign lcd_data_en = de_q;

  always_comb begin
    bus_rdata = 32'd0;
    if (hit) begin
      case (off)
        R_LCD_CTRL:      bus_rdata = {23'd0, pending_q, 7'd0, en_q};
        R_LCD_HTIM0:     bus_rdata = {6'd0, h_stage_q.bp, 6'd0, h_stage_q.sync};
        R_LCD_HTIM1:     bus_rdata = {6'd0, h_stage_q.fp, 6'd0, h_stage_q.act};
        R_LCD_VTIM0:     bus_rdata = {6'd0, v_stage_q.bp, 6'd0, v_stage_q.sync};
        R_LCD_VTIM1:     bus_rdata = {6'd0, v_stage_q.fp, 6'd0, v_stage_q.act};
        R_LCD_POS:       bus_rdata = {4'd0, vpos, 4'd0, hpos};
        R_LCD_FRAME_CNT: bus_rdata = fcnt_q;
        default:         bus_rdata = 32'd0;
      endcase
    end
  end

endmodule

// File: doc/lcd_timing_ctrl.md
# lcd_timing_ctrl

Bus-configurable LCD raster timing controller. It replaces the hard-coded 12.5 MHz hpos/vpos/sync generator in the top level. It generates pixel-rate strobes, raster counters and registered LCD control outputs (dotclk, hsync, vsync, data_en) from timing fields programmed over the SPI-slave bus. New timing values are shadowed and take effect only at a frame boundary. The pixel datapath (image fetch, border, lcd_db) consumes `hpos`/`vpos`/`pix_en` from this block.

## Interface
Parameters:
- `CLK_DIV`, default 4: clk cycles per pixel; legal values 2, 4, 8.
- `BASE`, default `BASE_LCD_CTRL`: bus base address; decode window is 32 bytes.

Ports:
- `clk` in 1: single clock. All logic runs in this domain.
- `rst_n` in 1: synchronous, active-low reset.
- `bus_addr` in 32: bus address from spi_slave.
- `bus_wdata` in 32: write data.
- `bus_wen` in 1: write strobe, one cycle.
- `bus_ren` in 1: read strobe (unused internally; reads have no side effects).
- `bus_rdata` out 32: combinational read data; 0 outside window.
- `pix_en` out 1: one-cycle strobe per pixel; counters update on it.
- `hpos` out 12: horizontal counter.
- `vpos` out 12: vertical counter.
- `frame_start` out 1: pulses with `pix_en` when the counters wrap to (0,0).
- `lcd_dotclk` out 1: registered pixel clock.
- `lcd_hsync` out 1: registered, active low.
- `lcd_vsync` out 1: registered, active low.
- `lcd_data_en` out 1: registered, high in the active area.

## Operation
- Registers (offset, access, layout):
  - 0x00 CTRL (RW): bit0 EN, reset value 1. bit8 PENDING is read-only.
  - 0x04 HTIM0: [9:0] h_sync, [25:16] h_bp. Reset 30/29.
  - 0x08 HTIM1: [9:0] h_act, [25:16] h_fp. Reset 320/29.
  - 0x0C VTIM0: v_sync/v_bp. Reset 8/7.
  - 0x10 VTIM1: v_act/v_fp. Reset 480/7.
  - 0x14 POS (RO): [11:0] hpos, [27:16] vpos.
  - 0x18 FRAME_CNT: 32-bit. Any write clears it.
- Writes to 0x04–0x10 update the staging copy and set PENDING.
- The active copy loads from staging, and PENDING clears, under either condition:
  - On the frame-wrap `pix_en`.
  - On every cycle while EN=0.
- Totals: htotal = h_sync+h_bp+h_act+h_fp, computed as a 12-bit unsigned value from the active copy; vtotal likewise. A total of 0 is treated as 1 (counter holds at 0).
- Counters advance only on `pix_en`.
  - hpos wraps from htotal-1 to 0; vpos increments on each hpos wrap.
  - vpos wraps from vtotal-1 to 0. That event is the frame wrap.
- Region decode from the counters:
  - hsync is low for hpos < h_sync; vsync is low for vpos < v_sync.
  - data_en is high for h_sync+h_bp ≤ hpos < h_sync+h_bp+h_act, and the equivalent vertical condition.
  - A zero h_act or v_act means data_en is never asserted.
- EN=0: divider, hpos and vpos held at 0; `pix_en`/`frame_start` held at 0; hsync=vsync=1; data_en=0; dotclk=0. On EN 0→1, the counters start from (0,0).
- FRAME_CNT increments on every frame wrap.

## Timing
- Reset (rst_n=0 at a clk edge), next cycle:
  - Divider=0, hpos=vpos=0, staging and active copies at reset values, PENDING=0, FRAME_CNT=0.
  - lcd_hsync=lcd_vsync=1, lcd_data_en=0, lcd_dotclk=0, pix_en=frame_start=0.
  - The same applies to reset mid-frame.
- Divider counts 0..CLK_DIV-1. `pix_en` = (divider==0 && EN), so the first `pix_en` occurs in the first cycle after reset release.
- `lcd_dotclk` <= divider MSB, registered.
- LCD outputs are registered from the current hpos/vpos: 1 clk latency after the counter value.
- Bus writes take effect on the clock edge of `bus_wen`. Reads are combinational, zero latency.
- Simultaneous events:
  - A staging write in the same cycle as the frame-wrap load: the load takes the pre-write staging value, PENDING stays 1, and the new value loads at the next wrap.
  - A FRAME_CNT clear coincident with an increment: the clear wins (result 0).
  - A CTRL write EN=0 mid-line: counters read 0 on the next cycle and the outputs are idle one cycle later.

## Structure
- `reg_map_pkg` gets:
  - `BASE_LCD_CTRL` (0xf800_2000).
  - Offsets `R_LCD_CTRL`…`R_LCD_FRAME_CNT`.
  - `typedef struct packed lcd_axis_t` {sync, bp, act, fp}, 10 bits each.
  - Reset constants `LCD_H_DEFAULT` and `LCD_V_DEFAULT`.
- One sub-module, `lcd_axis_gen`, instanced twice (horizontal and vertical):
  - Inputs: `lcd_axis_t`, a step enable.
  - Outputs: pos, wrap, sync_n, active.

## Test plan
- Reset, defaults, CLK_DIV=4 → `pix_en` every 4 clk; hpos wraps at 407; vpos wraps at 501; `frame_start` every 4·408·502 = 819,264 clk; hsync low for hpos 0–29; data_en first high with hpos=59, vpos=15 (one clk later).
- Write HTIM1=(h_fp=10,h_act=100) mid-frame → PENDING=1; htotal stays 408 until the frame wrap, then 169; PENDING reads 0.
- Write VTIM0 on the exact frame-wrap cycle → old value loaded; PENDING remains 1; new value active after the following wrap.
- CTRL=0 mid-line → next cycle hpos=vpos=0, then hsync=vsync=1, data_en=0; CTRL=1 → `pix_en` resumes, `frame_start` after one full frame.
- Run 3 frames, read FRAME_CNT=3; write FRAME_CNT on a wrap cycle → reads 0.
- rst_n=0 for one cycle at hpos=200, vpos=300 → all outputs and registers at their reset values; read HTIM0=0x001D_001E.
